// File: rtl/regfile_pkg.sv
// Shared types, default sizes and packing helper for the parametrised register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

  // Bit position of field `port` inside a packed vector of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: packed read ports, one write port, clear/status handshake.
interface regfile_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                clear_req;
  logic                ready;
  logic                clear_done;
  logic                wr_dropped;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clear_req,
    input  rd_data, ready, clear_done, wr_dropped
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clear_req,
    output rd_data, ready, clear_done, wr_dropped
  );
endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: sweeps every entry to zero after reset or on request, then
// raises ready and pulses clear_done for one cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          sweep_active,
  output logic [AW-1:0] sweep_idx,
  output logic          ready,
  output logic          clear_done
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        // The index wraps to 0 on its own after the last entry.
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ready_d = 1'b0;
          idx_d   = '0;
        end
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all sample pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign sweep_active = (state_q == CLEAR);
  assign sweep_idx    = idx_q;
  assign ready        = ready_q;
  assign clear_done   = done_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised integer register file with combinational read ports and a hardware clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int XLEN     = DEF_XLEN,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NRD      = DEF_NRD,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input logic     clk,
  input logic     rst_n,
  regfile_if.slave bus
);

  logic          sweep_active;
  logic [AW-1:0] sweep_idx;
  logic          ready;
  logic          clear_done;

  regfile_clear_fsm #(.NREGS(NREGS)) u_clear_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_req   (bus.clear_req),
    .sweep_active(sweep_active),
    .sweep_idx   (sweep_idx),
    .ready       (ready),
    .clear_done  (clear_done)
  );

  logic [XLEN-1:0] mem_q [NREGS];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            wr_dropped_q, wr_dropped_d;

  // The sweep owns the write port while clearing; the hardwired zero entry never stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (sweep_active) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_idx;
      mem_wdata = '0;
    end else if (bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0))) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array is deliberately not reset; the clear sweep zeroes it after reset instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign wr_dropped_d = wr_dropped_q | (bus.wr_en & sweep_active);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_dropped_q <= 1'b0;
    else        wr_dropped_q <= wr_dropped_d;
  end

  logic [NRD-1:0][XLEN-1:0] rd_data_w;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = bus.rd_addr[port_lsb(p, AW) +: AW];

    always_comb begin
      data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && ready && (addr == bus.wr_addr)) data = bus.wr_data;
`endif
      if (!ready || ((ZERO_REG != 0) && (addr == '0))) data = '0;
    end

    assign rd_data_w[p] = data;
  end

  assign bus.rd_data    = rd_data_w;
  assign bus.ready      = ready;
  assign bus.clear_done = clear_done;
  assign bus.wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: default build (32x32, 2 ports, zero reg) plus a
// 64-bit / 16-entry / 3-port / no-zero-reg instance; reads compared against a behavioural model.
module tb_regfile_param;

  localparam int NREGS_A = 32;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  regfile_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
  regfile_if #(.XLEN(64), .NREGS(16), .NRD(3)) bus_b ();

  regfile_param #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk  (clk),
    .rst_n(rst_a_n),
    .bus  (bus_a)
  );

  regfile_param #(.XLEN(64), .NREGS(16), .NRD(3), .ZERO_REG(0)) dut_b (
    .clk  (clk),
    .rst_n(rst_b_n),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of instance A: register contents, plus "edges left until usable" for the sweep.
  logic [31:0] m_mem [NREGS_A];
  int          m_left;
  bit          m_ready;
  bit          m_done;
  bit          m_drop;

  function automatic logic [31:0] exp_a(input logic [4:0] a);
    if (!m_ready || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus_a.wr_en && a == bus_a.wr_addr) return bus_a.wr_data;
`endif
    return m_mem[a];
  endfunction

  task automatic idle_inputs_a();
    bus_a.rd_addr   = '0;
    bus_a.wr_en     = 1'b0;
    bus_a.wr_addr   = '0;
    bus_a.wr_data   = '0;
    bus_a.clear_req = 1'b0;
  endtask

  task automatic apply_reset_a();
    idle_inputs_a();
    rst_a_n = 1'b0;
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_drop  = 1'b0;
    m_left  = NREGS_A;
  endtask

  // One rising edge of A: advance the model with the inputs present at the edge.
  task automatic edge_a();
    @(posedge clk);
    m_done = 1'b0;
    if (!rst_a_n) begin
      m_ready = 1'b0;
      m_drop  = 1'b0;
      m_left  = NREGS_A;
    end else if (!m_ready) begin
      if (bus_a.wr_en) m_drop = 1'b1;
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        m_done  = 1'b1;
        for (int i = 0; i < NREGS_A; i++) m_mem[i] = 32'd0;
      end
    end else begin
      if (bus_a.wr_en && bus_a.wr_addr != 5'd0) m_mem[bus_a.wr_addr] = bus_a.wr_data;
      if (bus_a.clear_req) begin
        m_ready = 1'b0;
        m_left  = NREGS_A;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int first_ready = -1;
    int done_cnt    = 0;
    apply_reset_a();
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (bus_a.ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got %0b expected 0", bus_a.ready);
    end
    n_checks++;
    if (bus_a.clear_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_clear_done: got %0b expected 0", bus_a.clear_done);
    end
    n_checks++;
    if (bus_a.wr_dropped !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr_dropped: got %0b expected 0", bus_a.wr_dropped);
    end
    rst_a_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      bus_a.rd_addr = {5'($urandom), 5'($urandom)};
      edge_a();
      n_checks++;
      if (bus_a.ready !== m_ready) begin
        n_fail++; $display("FAIL reset_sweep_ready edge %0d: got %0b expected %0b", c, bus_a.ready, m_ready);
      end
      n_checks++;
      if (bus_a.clear_done !== m_done) begin
        n_fail++; $display("FAIL reset_sweep_done edge %0d: got %0b expected %0b", c, bus_a.clear_done, m_done);
      end
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus_a.rd_data[p*32 +: 32] !== exp_a(bus_a.rd_addr[p*5 +: 5])) begin
          n_fail++; $display("FAIL reset_sweep_read port %0d edge %0d: got %h expected %h",
                             p, c, bus_a.rd_data[p*32 +: 32], exp_a(bus_a.rd_addr[p*5 +: 5]));
        end
      end
      if (bus_a.ready === 1'b1 && first_ready < 0) first_ready = c;
      if (bus_a.clear_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (first_ready != 32) begin
      n_fail++; $display("FAIL reset_ready_latency: got %0d edges expected 32", first_ready);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL reset_done_pulses: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_basic_write();
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd5;
    bus_a.wr_data = 32'hDEAD_BEEF;
    edge_a();
    bus_a.wr_en   = 1'b0;
    bus_a.rd_addr = {5'd5, 5'd5};
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bus_a.rd_data[p*32 +: 32] !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL write_reg5 port %0d: got %h expected deadbeef", p, bus_a.rd_data[p*32 +: 32]);
      end
    end
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd0;
    bus_a.wr_data = 32'h0000_1234;
    bus_a.rd_addr = {5'd0, 5'd0};
    edge_a();
    bus_a.wr_en = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bus_a.rd_data[p*32 +: 32] !== 32'd0) begin
        n_fail++; $display("FAIL write_reg0 port %0d: got %h expected 0", p, bus_a.rd_data[p*32 +: 32]);
      end
    end
    n_checks++;
    if (bus_a.wr_dropped !== 1'b0) begin
      n_fail++; $display("FAIL write_reg0_dropped: got %0b expected 0", bus_a.wr_dropped);
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] same_cycle;
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'hA5A5_A5A5;
`else
    same_cycle = 32'd0;
`endif
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd7;
    bus_a.wr_data = 32'hA5A5_A5A5;
    bus_a.rd_addr = {5'd7, 5'd7};
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bus_a.rd_data[p*32 +: 32] !== same_cycle) begin
        n_fail++; $display("FAIL rdw_same_cycle port %0d: got %h expected %h", p, bus_a.rd_data[p*32 +: 32], same_cycle);
      end
    end
    edge_a();
    bus_a.wr_en = 1'b0;
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (bus_a.rd_data[p*32 +: 32] !== 32'hA5A5_A5A5) begin
        n_fail++; $display("FAIL rdw_next_cycle port %0d: got %h expected a5a5a5a5", p, bus_a.rd_data[p*32 +: 32]);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    for (int c = 0; c < 60; c++) begin
      bus_a.wr_en   = 1'($urandom_range(0, 1));
      bus_a.wr_addr = 5'($urandom);
      bus_a.wr_data = $urandom;
      a0 = ($urandom_range(0, 2) == 0) ? bus_a.wr_addr : 5'($urandom);
      a1 = 5'($urandom);
      bus_a.rd_addr = {a1, a0};
      #1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus_a.rd_data[p*32 +: 32] !== exp_a(bus_a.rd_addr[p*5 +: 5])) begin
          n_fail++; $display("FAIL random_read port %0d cycle %0d addr %0d: got %h expected %h", p, c,
                             bus_a.rd_addr[p*5 +: 5], bus_a.rd_data[p*32 +: 32], exp_a(bus_a.rd_addr[p*5 +: 5]));
        end
      end
      edge_a();
    end
    bus_a.wr_en = 1'b0;
    n_checks++;
    if (bus_a.wr_dropped !== m_drop) begin
      n_fail++; $display("FAIL random_wr_dropped: got %0b expected %0b", bus_a.wr_dropped, m_drop);
    end
  endtask

  task automatic test_clear();
    int first_ready = -1;
    int done_cnt    = 0;
    // Make sure at least one register holds a nonzero value before the clear.
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = 5'd12;
    bus_a.wr_data = 32'h1357_9BDF;
    edge_a();
    bus_a.clear_req = 1'b1;
    bus_a.wr_addr   = 5'd9;
    bus_a.wr_data   = 32'hCAFE_F00D;
    edge_a();
    bus_a.clear_req = 1'b0;
    bus_a.wr_en     = 1'b0;
    n_checks++;
    if (bus_a.ready !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready_drop: got %0b expected 0", bus_a.ready);
    end
    for (int c = 1; c <= 40; c++) begin
      bus_a.wr_en     = (c == 10);
      bus_a.wr_addr   = 5'd3;
      bus_a.wr_data   = 32'h0BAD_0BAD;
      bus_a.clear_req = (c == 20);
      bus_a.rd_addr   = {5'($urandom), 5'($urandom)};
      #1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus_a.rd_data[p*32 +: 32] !== exp_a(bus_a.rd_addr[p*5 +: 5])) begin
          n_fail++; $display("FAIL clear_sweep_read port %0d cycle %0d: got %h expected %h", p, c,
                             bus_a.rd_data[p*32 +: 32], exp_a(bus_a.rd_addr[p*5 +: 5]));
        end
      end
      edge_a();
      n_checks++;
      if (bus_a.ready !== m_ready) begin
        n_fail++; $display("FAIL clear_sweep_ready edge %0d: got %0b expected %0b", c, bus_a.ready, m_ready);
      end
      if (bus_a.ready === 1'b1 && first_ready < 0) first_ready = c;
      if (bus_a.clear_done === 1'b1) done_cnt++;
    end
    bus_a.wr_en     = 1'b0;
    bus_a.clear_req = 1'b0;
    n_checks++;
    if (first_ready != 32) begin
      n_fail++; $display("FAIL clear_ready_latency: got %0d edges expected 32", first_ready);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL clear_done_pulses: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (bus_a.wr_dropped !== 1'b1) begin
      n_fail++; $display("FAIL clear_wr_dropped: got %0b expected 1", bus_a.wr_dropped);
    end
    for (int r = 0; r < NREGS_A; r += 2) begin
      bus_a.rd_addr = {5'(r + 1), 5'(r)};
      #1;
      for (int p = 0; p < 2; p++) begin
        n_checks++;
        if (bus_a.rd_data[p*32 +: 32] !== 32'd0) begin
          n_fail++; $display("FAIL clear_all_zero reg %0d: got %h expected 0", r + p, bus_a.rd_data[p*32 +: 32]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int first_ready = -1;
    int done_cnt    = 0;
    apply_reset_a();
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    for (int c = 0; c < 17; c++) edge_a();
    apply_reset_a();
    #1;
    n_checks++;
    if (bus_a.ready !== 1'b0 || bus_a.clear_done !== 1'b0 || bus_a.wr_dropped !== 1'b0) begin
      n_fail++; $display("FAIL midsweep_reset_outputs: got ready=%0b done=%0b dropped=%0b expected all 0",
                         bus_a.ready, bus_a.clear_done, bus_a.wr_dropped);
    end
    edge_a();
    rst_a_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      edge_a();
      n_checks++;
      if (bus_a.ready !== m_ready) begin
        n_fail++; $display("FAIL midsweep_ready edge %0d: got %0b expected %0b", c, bus_a.ready, m_ready);
      end
      if (bus_a.ready === 1'b1 && first_ready < 0) first_ready = c;
      if (bus_a.clear_done === 1'b1) done_cnt++;
    end
    n_checks++;
    if (first_ready != 32) begin
      n_fail++; $display("FAIL midsweep_ready_latency: got %0d edges expected 32", first_ready);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL midsweep_done_pulses: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_params_b();
    logic [63:0] mb [16];
    logic [3:0]  wa, r0, r1, r2;
    logic [63:0] wd;
    int          first_ready = -1;
    bus_b.rd_addr   = '0;
    bus_b.wr_en     = 1'b0;
    bus_b.wr_addr   = '0;
    bus_b.wr_data   = '0;
    bus_b.clear_req = 1'b0;
    rst_b_n = 1'b0;
    @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk);
      #1;
      if (bus_b.ready === 1'b1 && first_ready < 0) first_ready = c;
    end
    n_checks++;
    if (first_ready != 16) begin
      n_fail++; $display("FAIL b_ready_latency: got %0d edges expected 16", first_ready);
    end
    for (int i = 0; i < 16; i++) mb[i] = 64'd0;
    bus_b.wr_en   = 1'b1;
    bus_b.wr_addr = 4'd0;
    bus_b.wr_data = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk);
    #1;
    mb[0] = 64'hFFFF_0000_FFFF_0000;
    bus_b.wr_en   = 1'b0;
    bus_b.rd_addr = '0;
    #1;
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (bus_b.rd_data[p*64 +: 64] !== 64'hFFFF_0000_FFFF_0000) begin
        n_fail++; $display("FAIL b_reg0 port %0d: got %h expected ffff0000ffff0000", p, bus_b.rd_data[p*64 +: 64]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      wa = 4'($urandom);
      wd = {$urandom, $urandom};
      bus_b.wr_en   = 1'b1;
      bus_b.wr_addr = wa;
      bus_b.wr_data = wd;
      @(posedge clk);
      #1;
      mb[wa] = wd;
      bus_b.wr_en = 1'b0;
      r0 = wa;
      r1 = 4'($urandom);
      r2 = 4'($urandom);
      bus_b.rd_addr = {r2, r1, r0};
      #1;
      n_checks++;
      if (bus_b.rd_data[0 +: 64] !== mb[r0]) begin
        n_fail++; $display("FAIL b_random port 0 addr %0d: got %h expected %h", r0, bus_b.rd_data[0 +: 64], mb[r0]);
      end
      n_checks++;
      if (bus_b.rd_data[64 +: 64] !== mb[r1]) begin
        n_fail++; $display("FAIL b_random port 1 addr %0d: got %h expected %h", r1, bus_b.rd_data[64 +: 64], mb[r1]);
      end
      n_checks++;
      if (bus_b.rd_data[128 +: 64] !== mb[r2]) begin
        n_fail++; $display("FAIL b_random port 2 addr %0d: got %h expected %h", r2, bus_b.rd_data[128 +: 64], mb[r2]);
      end
    end
    n_checks++;
    if (bus_b.wr_dropped !== 1'b0) begin
      n_fail++; $display("FAIL b_wr_dropped: got %0b expected 0", bus_b.wr_dropped);
    end
  endtask

  initial begin
    rst_b_n = 1'b0;
    bus_b.rd_addr   = '0;
    bus_b.wr_en     = 1'b0;
    bus_b.wr_addr   = '0;
    bus_b.wr_data   = '0;
    bus_b.clear_req = 1'b0;
    test_reset();
    test_basic_write();
    test_read_during_write();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    test_params_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
